drain_collector: RTL
====================

# drain_collector

Output end of the systolic datapath: accepts a commit command (`ctrl_commit_t`) and then the per-column result streams (`drain_data_t`) drained out of the array. It reassembles the skewed column streams into full result rows and writes each row to the C memory as a `data_wire_t` write at `dest + row`. It is the counterpart of the feed path, which reads rows from memory and pushes `systolic_feed_t` into the array.

## Interface
Parameters:
- `N`, default `SYS_ARRAY_SIZE` (4): columns per row, and elements per column per drain.
- `DATA_WIDTH`, default `DATA_WIDTH` (8): width of one element.
- `ADDR_WIDTH`, default `ADDR_WIDTH` (10): width of the memory row address.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `clk_i`, in, 1: clock; all state changes on its rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `commit_i`, in, `ctrl_commit_t`: `valid` starts a drain; `dest` is the base row address.
- `drain_i`, in, `drain_data_t [N-1:0]`: one stream per column j; `enable` qualifies `data`.
- `wr_o`, out, `data_wire_t`: row write to C memory; `en` is a one-cycle strobe.
- `busy_o`, out, 1: drain in progress; commits are not accepted while high.
- `done_o`, out, 1: one-cycle pulse coinciding with the write of row N-1.
- `err_o`, out, 1: sticky protocol-error flag; cleared on the next accepted commit.

## Operation
States:
- IDLE → COLLECT when `commit_i.valid` is high and `busy_o` is low.
- COLLECT → IDLE in the cycle after the row N-1 write.

Commit acceptance:
- Latch `dest`, clear the column counters, row buffer, completion mask and `err_o`, and set `busy_o`.
- `commit_i.valid` while busy is ignored and sets `err_o`.

Column capture (COLLECT only):
- Each column j has a counter `cnt[j]` running 0..N.
- When `drain_i[j].enable` is high and `cnt[j] < N`: store `data` into `buf[cnt[j]][j]` and increment `cnt[j]`.
- When `drain_i[j].enable` is high and `cnt[j] == N`: drop the data and set `err_o`.
- Enables in IDLE, including the commit cycle itself, are ignored without error.

Row completion:
- Row r is complete when `cnt[j] > r` for all j.
- Columns deliver in row order, one element per cycle, so at most one row completes per cycle and rows complete strictly in order 0..N-1.
- A per-row `written` bit ensures each row is written exactly once.

Row packing:
- Column j occupies `row[j*DATA_WIDTH +: DATA_WIDTH]`; column 0 is in the LSBs.

Addressing:
- `wr_o.addr = dest + r`, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH (e.g. dest 1022, row 3 → addr 1).

Reset:
- Sets the state to IDLE and clears all counters, buffers and flags.
- All outputs reset to 0: `wr_o` = {addr 0, en 0, row 0}, `busy_o` = 0, `done_o` = 0, `err_o` = 0.
- A reset mid-drain discards partial rows; no write is issued for them.

## Timing
- `busy_o` rises in the cycle after commit acceptance.
- Drain data is accepted from that cycle onward.
- `wr_o` is registered: row r is written (`en` = 1) in the cycle after the capture edge that completes it.
- Minimum latency: last element captured → write is 1 cycle.
- Back-to-back row completions produce writes on consecutive cycles.
- `done_o` is high in the same cycle as the row N-1 write; `busy_o` falls the cycle after.
- A new commit is accepted the cycle `busy_o` is low; the earliest accepted commit is the cycle after `done_o`.
- Outside write cycles, `wr_o.en` = 0; `addr` and `row` hold their last values and are don't-care.
- Unskewed input (all columns enabled together for N cycles) yields N writes on N consecutive cycles, starting 1 cycle after the first capture.

## Test plan
- Reset with all inputs toggling → all outputs 0; no write issued.
- Commit dest=0x010, then 4 cycles with all columns enabled; `data[j]` = 4r+j → 4 writes at addresses 0x010..0x013. Row r = {4r+3, 4r+2, 4r+1, 4r}, column 0 in the LSBs. `done_o` coincides with addr 0x013.
- Skewed drain (column j starts j cycles late) → each row is written the cycle after column 3 delivers it. Writes are in order, exactly 4 total.
- dest=1022 → writes at addresses 1022, 1023, 0, 1.
- Commit while busy; also a fifth enable on column 2 → both are ignored, `err_o` = 1, and row data is unaffected. `err_o` clears on the next accepted commit.
- `rst_i` after 2 rows are written → no further writes and `busy_o` = 0. A fresh commit then drains correctly.

Source files
------------

// File: rtl/drain_collector.sv
// Reassembles skewed per-column drain streams into rows and writes each row to C memory at dest + row.
// Latency: a row is written 1 cycle after the capture edge that completes it; done_o rides on the last row write.
// Backpressure: none; commits during a drain and surplus column elements are dropped and flagged on err_o.
package drain_pkg;
    localparam int SYS_ARRAY_SIZE = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int ADDR_WIDTH     = 10;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] dest;
    } ctrl_commit_t;

    typedef struct packed {
        logic                  enable;
        logic [DATA_WIDTH-1:0] data;
    } drain_data_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]                addr;
        logic                                 en;
        logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0] row;
    } data_wire_t;
endpackage

module drain_collector #(
    parameter int N          = drain_pkg::SYS_ARRAY_SIZE,
    parameter int DATA_WIDTH = drain_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = drain_pkg::ADDR_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  drain_pkg::ctrl_commit_t          commit_i,
    input  drain_pkg::drain_data_t [N-1:0]   drain_i,
    output drain_pkg::data_wire_t            wr_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             err_o
);
    localparam int CW = $clog2(N + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   dest;
    logic [CW-1:0]           cnt     [N];
    logic [CW-1:0]           cnt_nxt [N];
    logic [DATA_WIDTH-1:0]   row_buf [N][N];
    logic [N-1:0]            written;

    logic [N-1:0]            cap;
    logic [N-1:0]            ovf;
    logic                    wr_hit;
    logic [RW-1:0]           wr_row;
    logic                    row_full;
    logic [N*DATA_WIDTH-1:0] row_dat;

    assign busy_o = (state == S_COLLECT);

    // Completion is judged on the post-capture counts so a row is written on the edge right after it fills.
    always_comb begin
        cap = '0;
        ovf = '0;
        for (int j = 0; j < N; j++) begin
            cnt_nxt[j] = cnt[j];
            if (state == S_COLLECT && drain_i[j].enable) begin
                if (cnt[j] != CW'(N)) begin
                    cap[j]     = 1'b1;
                    cnt_nxt[j] = cnt[j] + 1'b1;
                end else begin
                    ovf[j] = 1'b1;
                end
            end
        end

        wr_hit   = 1'b0;
        wr_row   = '0;
        row_full = 1'b0;
        for (int r = 0; r < N; r++) begin
            row_full = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (cnt_nxt[j] <= CW'(r)) row_full = 1'b0;
            end
            if (!wr_hit && !written[r] && row_full) begin
                wr_hit = 1'b1;
                wr_row = RW'(r);
            end
        end

        // Columns finishing this row in the current cycle are not yet in row_buf.
        row_dat = '0;
        for (int j = 0; j < N; j++) begin
            row_dat[j*DATA_WIDTH +: DATA_WIDTH] =
                (cap[j] && cnt[j] == CW'(wr_row)) ? drain_i[j].data : row_buf[wr_row][j];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            dest    <= '0;
            written <= '0;
            wr_o    <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            for (int j = 0; j < N; j++) begin
                cnt[j] <= '0;
                for (int r = 0; r < N; r++) row_buf[r][j] <= '0;
            end
        end else begin
            wr_o.en <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (commit_i.valid) begin
                        state   <= S_COLLECT;
                        dest    <= commit_i.dest;
                        written <= '0;
                        err_o   <= 1'b0;
                        for (int j = 0; j < N; j++) begin
                            cnt[j] <= '0;
                            for (int r = 0; r < N; r++) row_buf[r][j] <= '0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (commit_i.valid || (|ovf)) err_o <= 1'b1;
                    for (int j = 0; j < N; j++) begin
                        if (cap[j]) row_buf[cnt[j][RW-1:0]][j] <= drain_i[j].data;
                        cnt[j] <= cnt_nxt[j];
                    end
                    if (wr_hit) begin
                        wr_o.en         <= 1'b1;
                        wr_o.addr       <= dest + ADDR_WIDTH'(wr_row);
                        wr_o.row        <= row_dat;
                        written[wr_row] <= 1'b1;
                        if (wr_row == RW'(N - 1)) done_o <= 1'b1;
                    end
                    if (done_o) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
